// File: rtl/altr_hps_ifreg_scan_ctrl.sv
// Sequencer for a serial chain of scan-muxed interface registers.
// A request can start with one functional capture cycle, then shifts CHAIN_LEN bits.
// During the shift, the latched wdata goes into the head of the chain, and the old
// chain contents coming off the tail are collected into rdata.
module altr_hps_ifreg_scan_ctrl #(
    parameter int CHAIN_LEN = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req,
    input  logic                 capture,
    input  logic                 abort,
    input  logic [CHAIN_LEN-1:0] wdata,
    input  logic                 scan_out,
    output logic                 scanen,
    output logic                 scan_in,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] rdata
);

    localparam int               CNT_W    = $clog2(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        CAPT,
        SHIFT,
        DONE
    } state_t;

    state_t               state;
    state_t               next_state;
    logic                 accept;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_next;
    logic [CHAIN_LEN-1:0] wdata_sh;
    logic [CHAIN_LEN-1:0] wdata_sh_next;
    logic [CHAIN_LEN-1:0] cap_sr;
    logic [CHAIN_LEN-1:0] cap_sr_next;
    logic                 scanen_d;
    logic                 scan_in_d;
    logic                 busy_d;
    logic                 done_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; abort always beats a simultaneous req, and req is only honoured in IDLE
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (req && !abort) begin
                    accept     = 1'b1;
                    next_state = capture ? CAPT : SHIFT;
                end
            end
            CAPT: begin
                next_state = abort ? IDLE : SHIFT;
            end
            SHIFT: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (cnt == LAST_CNT) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Next values for the shift counter, wdata shadow and tail capture register
    always_comb begin
        cnt_next      = cnt;
        wdata_sh_next = wdata_sh;
        cap_sr_next   = cap_sr;
        if (accept) begin
            cnt_next      = '0;
            wdata_sh_next = wdata;
        end else if ((state == SHIFT) && (next_state == SHIFT)) begin
            cnt_next = cnt + CNT_W'(1);
        end
        if (state == SHIFT) begin
            cap_sr_next[cnt] = scan_out;
        end
    end

    // Output decode from the upcoming state; registered so the chain sees clean, glitch-free controls
    always_comb begin
        scanen_d  = (next_state == SHIFT);
        busy_d    = (next_state == CAPT) || (next_state == SHIFT);
        done_d    = (next_state == DONE);
        scan_in_d = 1'b0;
        if (next_state == SHIFT) begin
            scan_in_d = wdata_sh_next[cnt_next];
        end
    end

    // Datapath and output registers; rdata picks up the final tail bit on the edge entering DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            wdata_sh <= '0;
            cap_sr   <= '0;
            rdata    <= '0;
            scanen   <= 1'b0;
            scan_in  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            cnt      <= cnt_next;
            wdata_sh <= wdata_sh_next;
            cap_sr   <= cap_sr_next;
            scanen   <= scanen_d;
            scan_in  <= scan_in_d;
            busy     <= busy_d;
            done     <= done_d;
            if ((state == SHIFT) && (next_state == DONE)) begin
                rdata <= cap_sr_next;
            end
        end
    end

endmodule

// File: tb/tb_altr_hps_ifreg_scan_ctrl.sv
// Bench for altr_hps_ifreg_scan_ctrl: an 8-long and a 2-long instance, each wired to a
// behavioural scan chain. The chain loads data_in whenever scanen is low.
// Expected rdata values are queued when an operation is launched and popped when done is due.
module tb_altr_hps_ifreg_scan_ctrl;

    logic clk = 1'b0;
    logic rst_n;

    logic       req_a, capture_a, abort_a, scan_out_a;
    logic       scanen_a, scan_in_a, busy_a, done_a;
    logic [7:0] wdata_a, rdata_a, data_in_a, chain_a;

    logic       req_b, capture_b, abort_b, scan_out_b;
    logic       scanen_b, scan_in_b, busy_b, done_b;
    logic [1:0] wdata_b, rdata_b, data_in_b, chain_b;

    logic [7:0] exp_q[$];
    logic [1:0] exp_b_q[$];

    int tests_run    = 0;
    int tests_failed = 0;

    // Free-running clock
    always #5 clk = ~clk;

    altr_hps_ifreg_scan_ctrl #(.CHAIN_LEN(8)) dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req_a),
        .capture  (capture_a),
        .abort    (abort_a),
        .wdata    (wdata_a),
        .scan_out (scan_out_a),
        .scanen   (scanen_a),
        .scan_in  (scan_in_a),
        .busy     (busy_a),
        .done     (done_a),
        .rdata    (rdata_a)
    );

    altr_hps_ifreg_scan_ctrl #(.CHAIN_LEN(2)) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req_b),
        .capture  (capture_b),
        .abort    (abort_b),
        .wdata    (wdata_b),
        .scan_out (scan_out_b),
        .scanen   (scanen_b),
        .scan_in  (scan_in_b),
        .busy     (busy_b),
        .done     (done_b),
        .rdata    (rdata_b)
    );

    // Interface register chains: position 0 is the head, and the top bit is the tail
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_a <= '0;
            chain_b <= '0;
        end else begin
            chain_a <= scanen_a ? {chain_a[6:0], scan_in_a} : data_in_a;
            chain_b <= scanen_b ? {chain_b[0], scan_in_b} : data_in_b;
        end
    end

    assign scan_out_a = chain_a[7];
    assign scan_out_b = chain_b[1];

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse req for one cycle; returns at the falling edge of the first cycle after acceptance
    task automatic apply_stimulus(input bit cap, input logic [7:0] wd);
        @(negedge clk);
        req_a     = 1'b1;
        capture_a = cap;
        wdata_a   = wd;
        @(negedge clk);
        req_a     = 1'b0;
        capture_a = 1'b0;
        wdata_a   = ~wd;
    endtask

    // Full 8-bit operation with cycle-exact checks; src is the chain content that the shift unloads
    task automatic run_op8(input bit cap, input logic [7:0] wd, input logic [7:0] src);
        data_in_a = cap ? ~src : src;
        exp_q.push_back(rev8(src));
        apply_stimulus(cap, wd);
        if (cap) begin
            check_output("capt_scanen", 32'(scanen_a), 32'(0));
            check_output("capt_busy", 32'(busy_a), 32'(1));
            data_in_a = src;
            @(negedge clk);
            data_in_a = ~src;
        end
        for (int k = 0; k < 8; k++) begin
            check_output("shift_scanen", 32'(scanen_a), 32'(1));
            check_output("shift_busy", 32'(busy_a), 32'(1));
            check_output("shift_scan_in", 32'(scan_in_a), 32'(wd[k]));
            @(negedge clk);
        end
        check_output("done_pulse", 32'(done_a), 32'(1));
        check_output("done_busy", 32'(busy_a), 32'(0));
        check_output("done_scanen", 32'(scanen_a), 32'(0));
        check_output("done_rdata", 32'(rdata_a), 32'(exp_q.pop_front()));
        check_output("done_chain", 32'(chain_a), 32'(rev8(wd)));
        @(negedge clk);
        check_output("after_done", 32'(done_a), 32'(0));
    endtask

    // Directed sequence
    initial begin
        rst_n     = 1'b0;
        req_a     = 1'b0;
        capture_a = 1'b0;
        abort_a   = 1'b0;
        wdata_a   = '0;
        data_in_a = '0;
        req_b     = 1'b0;
        capture_b = 1'b0;
        abort_b   = 1'b0;
        wdata_b   = '0;
        data_in_b = '0;
        #1;
        check_output("rst_scanen", 32'(scanen_a), 32'(0));
        check_output("rst_busy", 32'(busy_a), 32'(0));
        check_output("rst_done", 32'(done_a), 32'(0));
        check_output("rst_rdata", 32'(rdata_a), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] plain shift, chain preloaded 0x3C, wdata 0xA5");
        run_op8(1'b0, 8'hA5, 8'h3C);

        $display("[TB] abort in shift cycle 3");
        data_in_a = 8'hF0;
        apply_stimulus(1'b0, 8'h77);
        repeat (3) @(negedge clk);
        check_output("abort_pre_scanen", 32'(scanen_a), 32'(1));
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        check_output("abort_scanen", 32'(scanen_a), 32'(0));
        check_output("abort_busy", 32'(busy_a), 32'(0));
        check_output("abort_scan_in", 32'(scan_in_a), 32'(0));
        for (int i = 0; i < 10; i++) begin
            check_output("abort_no_done", 32'(done_a), 32'(0));
            @(negedge clk);
        end
        check_output("abort_rdata", 32'(rdata_a), 32'(8'h3C));
        req_a   = 1'b1;
        abort_a = 1'b1;
        @(negedge clk);
        req_a   = 1'b0;
        abort_a = 1'b0;
        check_output("abort_wins_busy", 32'(busy_a), 32'(0));
        check_output("abort_wins_scanen", 32'(scanen_a), 32'(0));

        $display("[TB] capture then shift, data_in 0x5A during capture");
        run_op8(1'b1, 8'hC1, 8'h5A);

        $display("[TB] req held high");
        @(negedge clk);
        data_in_a = 8'h0D;
        wdata_a   = 8'h96;
        capture_a = 1'b0;
        req_a     = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(rev8(8'h0D));
        @(posedge clk);
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            check_output("held_busy", 32'(busy_a), 32'(((n - 1) % 10) < 8));
            check_output("held_done", 32'(done_a), 32'(((n - 1) % 10) == 8));
            if (((n - 1) % 10) == 8) begin
                check_output("held_rdata", 32'(rdata_a), 32'(exp_q.pop_front()));
            end
        end
        req_a = 1'b0;
        @(negedge clk);
        check_output("held_stop_busy", 32'(busy_a), 32'(0));

        $display("[TB] async reset mid-shift");
        data_in_a = 8'h3C;
        apply_stimulus(1'b0, 8'hFF);
        @(negedge clk);
        check_output("pre_rst_scanen", 32'(scanen_a), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        check_output("arst_scanen", 32'(scanen_a), 32'(0));
        check_output("arst_busy", 32'(busy_a), 32'(0));
        check_output("arst_done", 32'(done_a), 32'(0));
        check_output("arst_scan_in", 32'(scan_in_a), 32'(0));
        check_output("arst_rdata", 32'(rdata_a), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_output("post_rst_done", 32'(done_a), 32'(0));
        check_output("post_rst_busy", 32'(busy_a), 32'(0));

        $display("[TB] two-register chain");
        data_in_b = 2'b01;
        exp_b_q.push_back(2'b10);
        @(negedge clk);
        req_b   = 1'b1;
        wdata_b = 2'b10;
        @(negedge clk);
        req_b   = 1'b0;
        wdata_b = 2'b01;
        check_output("len2_scanen0", 32'(scanen_b), 32'(1));
        check_output("len2_scan_in0", 32'(scan_in_b), 32'(0));
        @(negedge clk);
        check_output("len2_scanen1", 32'(scanen_b), 32'(1));
        check_output("len2_scan_in1", 32'(scan_in_b), 32'(1));
        @(negedge clk);
        check_output("len2_done", 32'(done_b), 32'(1));
        check_output("len2_done_scanen", 32'(scanen_b), 32'(0));
        check_output("len2_rdata", 32'(rdata_b), 32'(exp_b_q.pop_front()));
        check_output("len2_chain", 32'(chain_b), 32'(2'b01));
        @(negedge clk);
        check_output("len2_after_done", 32'(done_b), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
